// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the sequential multiply/divide unit.
//   op_e    - operation encoding carried on the op port
//   state_e - control FSM states
//   cnt_w   - iteration counter width for a given operand width
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MULU = 2'd1,
        OP_DIV  = 2'd2,
        OP_DIVU = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_muldiv_if.sv
// seq_muldiv_if: request/response bundle of the multiply/divide unit.
//   start, kill, op, a, b        - requester -> unit
//   busy, done, result_lo/hi     - unit -> requester
// master: the requester (control unit / testbench); slave: seq_muldiv.
interface seq_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, kill, op, a, b,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, kill, op, a, b,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: N-bit ripple adder/subtractor built from 1-bit full-adder cells.
//   x, y  - operands
//   sub   - 0: sum = x + y + cin ; 1: sum = x + ~y + cin (cin=1 gives x - y)
//   cin   - carry into bit 0
//   sum   - result
//   cout  - carry out of the top cell; in subtract mode 1 means "no borrow"
module muldiv_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0]   c;
    logic [N-1:0] y_eff;

    assign y_eff = y ^ {N{sub}};
    assign c[0]  = cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign sum[i]   = x[i] ^ y_eff[i] ^ c[i];
        assign c[i+1]   = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end

    assign cout = c[N];
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative signed/unsigned multiply and restoring divide,
// one operand bit per cycle, WIDTH+2 cycles from start to done.
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   bus      - seq_muldiv_if slave: start/kill/op/a/b in,
//              busy/done/result_lo/result_hi out (all outputs registered)
// Two shared add/sub units do all arithmetic: in IDLE they negate the
// incoming operands, in CALC the high unit accumulates or trial-subtracts,
// and in FIX they negate the final result words.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    seq_muldiv_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_r, state_nx;
    op_e              op_r;
    logic             sa_r, sb_r, bz_r;
    logic [WIDTH-1:0] opnd_r, a_r, acc_hi_r, acc_lo_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_lo_r, res_hi_r;
    logic             done_r;

    logic [WIDTH-1:0] lo_x, lo_y, lo_sum;
    logic             lo_sub, lo_cin, lo_co;
    logic [WIDTH:0]   hi_x, hi_y, hi_sum;
    logic             hi_sub, hi_cin, hi_co;

    logic             is_mul;
    logic             in_mul, in_sgn, in_sa, in_sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_lo, fix_hi;

    muldiv_addsub #(.N(WIDTH)) u_lo (
        .x(lo_x), .y(lo_y), .sub(lo_sub), .cin(lo_cin), .sum(lo_sum), .cout(lo_co)
    );

    muldiv_addsub #(.N(WIDTH + 1)) u_hi (
        .x(hi_x), .y(hi_y), .sub(hi_sub), .cin(hi_cin), .sum(hi_sum), .cout(hi_co)
    );

    assign is_mul = (op_r == OP_MUL) || (op_r == OP_MULU);
    assign in_mul = (bus.op == OP_MUL) || (bus.op == OP_MULU);
    assign in_sgn = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign in_sa  = in_sgn & bus.a[WIDTH-1];
    assign in_sb  = in_sgn & bus.b[WIDTH-1];
    // Negated MIN stays MIN, which read unsigned is the correct magnitude 2^(W-1).
    assign mag_a  = in_sa ? lo_sum : bus.a;
    assign mag_b  = in_sb ? hi_sum[WIDTH-1:0] : bus.b;

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt_r == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.kill && (state_r != IDLE)) state_nx = IDLE;
    end

    // Add/sub operand steering; default is "negate y" (0 - y).
    always_comb begin
        lo_x   = '0;
        lo_y   = '0;
        lo_sub = 1'b1;
        lo_cin = 1'b1;
        hi_x   = '0;
        hi_y   = '0;
        hi_sub = 1'b1;
        hi_cin = 1'b1;
        case (state_r)
            IDLE: begin
                lo_y = bus.a;
                hi_y = {1'b0, bus.b};
            end
            CALC: begin
                if (is_mul) begin
                    hi_x   = {1'b0, acc_hi_r};
                    hi_y   = acc_lo_r[0] ? {1'b0, opnd_r} : '0;
                    hi_sub = 1'b0;
                    hi_cin = 1'b0;
                end else begin
                    // Partial remainder shifted left with the next dividend bit.
                    hi_x = {acc_hi_r, acc_lo_r[WIDTH-1]};
                    hi_y = {1'b0, opnd_r};
                end
            end
            FIX: begin
                lo_y = acc_lo_r;
                hi_y = {1'b0, acc_hi_r};
                // 2W-bit negate: the low word's carry ripples into the high word.
                if (is_mul) hi_cin = lo_co;
            end
            default: ;
        endcase
    end

    always_comb begin
        fix_lo = acc_lo_r;
        fix_hi = acc_hi_r;
        if (is_mul) begin
            if (sa_r ^ sb_r) begin
                fix_lo = lo_sum;
                fix_hi = hi_sum[WIDTH-1:0];
            end
        end else if (bz_r) begin
            fix_lo = '1;
            fix_hi = a_r;
        end else begin
            if (sa_r ^ sb_r) fix_lo = lo_sum;
            if (sa_r)        fix_hi = hi_sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            done_r   <= 1'b0;
            res_lo_r <= '0;
            res_hi_r <= '0;
        end else begin
            state_r <= state_nx;
            done_r  <= 1'b0;
            if (state_r == IDLE)      cnt_r <= '0;
            else if (state_r == CALC) cnt_r <= cnt_r + CW'(1);
            if (bus.kill && (state_r != IDLE)) begin
                res_lo_r <= '0;
                res_hi_r <= '0;
            end else if (state_r == FIX) begin
                res_lo_r <= fix_lo;
                res_hi_r <= fix_hi;
                done_r   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    op_r     <= bus.op;
                    sa_r     <= in_sa;
                    sb_r     <= in_sb;
                    bz_r     <= (bus.b == '0);
                    a_r      <= bus.a;
                    opnd_r   <= in_mul ? mag_a : mag_b;
                    acc_lo_r <= in_mul ? mag_b : mag_a;
                    acc_hi_r <= '0;
                end
            end
            CALC: begin
                if (is_mul) begin
                    acc_hi_r <= hi_sum[WIDTH:1];
                    acc_lo_r <= {hi_sum[0], acc_lo_r[WIDTH-1:1]};
                end else begin
                    // hi_co=1: trial subtract did not borrow, keep the difference.
                    acc_hi_r <= hi_co ? hi_sum[WIDTH-1:0] : hi_x[WIDTH-1:0];
                    acc_lo_r <= {acc_lo_r[WIDTH-2:0], hi_co};
                end
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
    assign bus.result_lo = res_lo_r;
    assign bus.result_hi = res_hi_r;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: directed and randomized checks of seq_muldiv at WIDTH=32 and
// WIDTH=8 against an arithmetic reference model.
module tb_seq_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_muldiv_if #(.WIDTH(32)) i32 ();
    seq_muldiv_if #(.WIDTH(8))  i8 ();

    seq_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(i32));
    seq_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(i8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {remainder/high, quotient/low}, each in a 32-bit field.
    function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, sa, sb, q, r;
        mask = (longint'(1) << w) - 1;
        if (op[0]) begin
            sa = longint'(a) & mask;
            sb = longint'(b) & mask;
        end else begin
            sa = (longint'(a) << (64 - w)) >>> (64 - w);
            sb = (longint'(b) << (64 - w)) >>> (64 - w);
        end
        if (!op[1]) begin
            q = sa * sb;
            r = q >>> w;
        end else if ((longint'(b) & mask) == 0) begin
            q = mask;
            r = longint'(a) & mask;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {32'(r & mask), 32'(q & mask)};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Runs one op on the 32-bit unit; can inject an ignored start or a kill at a given cycle.
    task automatic op32(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int ignore_at, input int kill_at,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output int lat, output int bcnt, output bit got_done);
        @(negedge clk);
        i32.start = 1'b1; i32.op = op; i32.a = a; i32.b = b;
        @(negedge clk);
        i32.start = 1'b0;
        lat = 1; bcnt = 0; got_done = 0;
        while (lat < 60) begin
            if (i32.done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (i32.busy === 1'b1) bcnt++;
            if (lat == ignore_at) begin
                i32.start = 1'b1; i32.op = OP_MULU; i32.a = 32'h1234; i32.b = 32'h5678;
            end else begin
                i32.start = 1'b0;
            end
            i32.kill = (lat == kill_at);
            @(negedge clk);
            lat++;
            if (kill_at > 0 && lat == kill_at + 1) begin
                chk("kill_busy", {63'd0, i32.busy}, 64'd0);
                chk("kill_lo", {32'd0, i32.result_lo}, 64'd0);
                chk("kill_hi", {32'd0, i32.result_hi}, 64'd0);
            end
        end
        i32.start = 1'b0;
        i32.kill  = 1'b0;
        lo = i32.result_lo;
        hi = i32.result_hi;
    endtask

    // Runs one op on the 8-bit unit; chain=1 drives start in the current (done) cycle.
    task automatic op8(input op_e op, input logic [7:0] a, input logic [7:0] b, input bit chain,
                       output logic [7:0] lo, output logic [7:0] hi, output int lat);
        if (!chain) @(negedge clk);
        i8.start = 1'b1; i8.op = op; i8.a = a; i8.b = b;
        @(negedge clk);
        i8.start = 1'b0;
        lat = 1;
        while (i8.done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        lo = i8.result_lo;
        hi = i8.result_hi;
    endtask

    initial begin
        logic [31:0] lo, hi, ra, rb;
        logic [7:0]  lo8, hi8, ra8, rb8;
        logic [63:0] exp;
        int          lat, bcnt, ndone;
        bit          gd;
        op_e         rop;

        i32.start = 0; i32.kill = 0; i32.op = OP_MUL; i32.a = 0; i32.b = 0;
        i8.start = 0;  i8.kill = 0;  i8.op = OP_MUL;  i8.a = 0;  i8.b = 0;

        // Reset, with start and kill asserted to show reset wins.
        i32.start = 1; i32.kill = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, i32.busy}, 64'd0);
        chk("rst_done", {63'd0, i32.done}, 64'd0);
        chk("rst_lo", {32'd0, i32.result_lo}, 64'd0);
        chk("rst_hi", {32'd0, i32.result_hi}, 64'd0);
        chk("rst8_busy", {63'd0, i8.busy}, 64'd0);
        i32.start = 0; i32.kill = 0;
        reset_n = 1'b1;

        // Signed MUL with latency / busy-length checks.
        op32(OP_MUL, 32'd7, 32'hFFFF_FFFD, 0, 0, lo, hi, lat, bcnt, gd);
        chk("mul_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFEB});
        chk("mul_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("mul_lat", 64'(lat), 64'd34);
        chk("mul_busy_cycles", 64'(bcnt), 64'd33);
        chk("mul_busy_at_done", {63'd0, i32.busy}, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, i32.done}, 64'd0);
        chk("hold_lo", {32'd0, i32.result_lo}, {32'd0, 32'hFFFF_FFEB});

        op32(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lo, hi, lat, bcnt, gd);
        chk("mulu_lo", {32'd0, lo}, 64'd1);
        chk("mulu_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFE});

        op32(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, lo, hi, lat, bcnt, gd);
        chk("div_neg_q", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
        chk("div_neg_r", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});

        op32(OP_DIVU, 32'd7, 32'd2, 0, 0, lo, hi, lat, bcnt, gd);
        chk("divu_q", {32'd0, lo}, 64'd3);
        chk("divu_r", {32'd0, hi}, 64'd1);

        op32(OP_DIV, 32'd5, 32'd0, 0, 0, lo, hi, lat, bcnt, gd);
        chk("div0_q", {32'd0, lo}, {32'd0, 32'hFFFF_FFFF});
        chk("div0_r", {32'd0, hi}, 64'd5);

        op32(OP_DIVU, 32'hDEAD_BEEF, 32'd0, 0, 0, lo, hi, lat, bcnt, gd);
        chk("divu0_q", {32'd0, lo}, {32'd0, 32'hFFFF_FFFF});
        chk("divu0_r", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});

        op32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lo, hi, lat, bcnt, gd);
        chk("minneg1_q", {32'd0, lo}, {32'd0, 32'h8000_0000});
        chk("minneg1_r", {32'd0, hi}, 64'd0);

        // Start while busy is ignored.
        op32(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5, 0, lo, hi, lat, bcnt, gd);
        chk("ign_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFEB});
        chk("ign_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("ign_lat", 64'(lat), 64'd34);
        @(negedge clk);
        chk("ign_not_restarted", {63'd0, i32.busy}, 64'd0);

        // Kill in IDLE leaves results untouched.
        i32.kill = 1'b1;
        @(negedge clk);
        i32.kill = 1'b0;
        chk("idle_kill_lo", {32'd0, i32.result_lo}, {32'd0, 32'hFFFF_FFEB});
        chk("idle_kill_busy", {63'd0, i32.busy}, 64'd0);

        // Kill at cycle 10: busy drops, results cleared, no done.
        op32(OP_MULU, 32'd1000, 32'd3, 0, 10, lo, hi, lat, bcnt, gd);
        chk("kill_no_done", {63'd0, gd}, 64'd0);

        // Kill together with start in IDLE: start wins.
        @(negedge clk);
        i32.start = 1; i32.kill = 1; i32.op = OP_DIVU; i32.a = 32'd100; i32.b = 32'd9;
        @(negedge clk);
        i32.start = 0; i32.kill = 0;
        chk("kill_start_busy", {63'd0, i32.busy}, 64'd1);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (i32.done === 1'b1) begin
                ndone++;
                chk("kill_start_q", {32'd0, i32.result_lo}, 64'd11);
                chk("kill_start_r", {32'd0, i32.result_hi}, 64'd1);
            end
        end
        chk("kill_start_done", 64'(ndone), 64'd1);

        // Reset mid-operation.
        @(negedge clk);
        i32.start = 1; i32.op = OP_DIVU; i32.a = 32'd1000; i32.b = 32'd7;
        @(negedge clk);
        i32.start = 0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {63'd0, i32.busy}, 64'd0);
        chk("midrst_done", {63'd0, i32.done}, 64'd0);
        chk("midrst_lo", {32'd0, i32.result_lo}, 64'd0);
        chk("midrst_hi", {32'd0, i32.result_hi}, 64'd0);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (i32.done === 1'b1) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);

        // Randomized 32-bit ops against the model.
        for (int n = 0; n < 24; n++) begin
            rop = op_e'($urandom_range(0, 3));
            ra = pick32();
            rb = pick32();
            op32(rop, ra, rb, 0, 0, lo, hi, lat, bcnt, gd);
            exp = model(32, rop, ra, rb);
            chk("rnd32_lo", {32'd0, lo}, {32'd0, exp[31:0]});
            chk("rnd32_hi", {32'd0, hi}, {32'd0, exp[63:32]});
            chk("rnd32_lat", 64'(lat), 64'd34);
        end

        // Back-to-back at WIDTH=8.
        op8(OP_MUL, 8'h80, 8'hFF, 1'b0, lo8, hi8, lat);
        chk("b2b_mul_lo", {56'd0, lo8}, 64'h80);
        chk("b2b_mul_hi", {56'd0, hi8}, 64'h00);
        chk("b2b_mul_lat", 64'(lat), 64'd10);
        op8(OP_DIVU, 8'd200, 8'd7, 1'b1, lo8, hi8, lat);
        chk("b2b_divu_q", {56'd0, lo8}, 64'd28);
        chk("b2b_divu_r", {56'd0, hi8}, 64'd4);
        chk("b2b_divu_lat", 64'(lat), 64'd10);

        // Randomized 8-bit ops, chained back-to-back.
        for (int n = 0; n < 40; n++) begin
            rop = op_e'($urandom_range(0, 3));
            ra8 = 8'($urandom_range(0, 255));
            rb8 = (n % 7 == 0) ? 8'd0 : ((n % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            op8(rop, ra8, rb8, 1'b1, lo8, hi8, lat);
            exp = model(8, rop, {24'd0, ra8}, {24'd0, rb8});
            chk("rnd8_lo", {56'd0, lo8}, {56'd0, exp[7:0]});
            chk("rnd8_hi", {56'd0, hi8}, {56'd0, exp[39:32]});
            chk("rnd8_lat", 64'(lat), 64'd10);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised iterative multiply/divide unit for the core's ALU, replacing the fixed 32-bit shift-add multiplier. It adds unsigned modes, a full double-width product, and restoring division producing quotient and remainder. Operands are captured on a start handshake, one bit is processed per cycle, and the unit signals completion with a single-cycle done pulse. The control unit stalls `pc` while `busy` is high, then writes the result.

## Interface
- `WIDTH`, default 32: operand width in bits; legal values are 4 and above.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `kill`  in  1  aborts an operation in flight; no `done` is produced.
- `op`  in  2  0=MUL signed, 1=MULU unsigned, 2=DIV signed, 3=DIVU unsigned; sampled with `start`.
- `a`  in  WIDTH  multiplicand or dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results are valid in the same cycle.
- `result_lo`  out  WIDTH  MUL: product bits [WIDTH-1:0]; DIV: quotient.
- `result_hi`  out  WIDTH  MUL: product bits [2W-1:WIDTH]; DIV: remainder.

## Operation
- **States:** IDLE, CALC, FIX.
  - IDLE→CALC on `start`.
  - CALC→FIX when the iteration counter reaches WIDTH.
  - FIX→IDLE unconditionally, asserting `done` in the following cycle.
- **On accept:**
  - Latch `op`.
  - Latch the sign flags: signed modes only, (a MSB) and (b MSB).
  - Latch the operand magnitudes: two's-complement negate if signed and negative. The magnitude of the minimum signed value is 2^(W-1), treated as unsigned.
  - Clear the accumulators and clear the counter.
- **MUL/MULU:**
  - Shift-add on magnitudes into a 2W-bit accumulator, one multiplier bit per CALC cycle.
  - In FIX, negate the full 2W result if the sign flags differ (signed only).
- **DIV/DIVU:**
  - Restoring division with a (WIDTH+1)-bit partial remainder, dividend bits shifted in MSB-first.
  - Each cycle: trial-subtract the divisor; if there is no borrow, keep the difference and set the quotient bit to 1.
  - In FIX:
    - Negate the quotient if the signs differ.
    - Negate the remainder if the dividend is negative, so the remainder sign follows the dividend.
- **Special cases, applied in FIX:**
  - Divisor 0: quotient is all-ones and remainder equals `a`, for both signed and unsigned.
  - Signed MIN/−1: quotient is MIN and remainder is 0; the datapath produces this naturally.
- `result_lo` and `result_hi` are registered and hold their value until the next completion. `kill` and reset also clear them to 0.
- `start` while `busy`=1 is ignored; no queueing.

## Timing
- **Reset** (`reset_n`=0 at an edge): state→IDLE, `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, counter=0. Reset wins over `start` and `kill`. Reset mid-operation discards the operation and produces no `done`.
- **Latency:** `start` is sampled high at edge E0. `busy`=1 from after E0 through E(W+1). `done`=1 and results are valid after E(W+1), for exactly one cycle. The total is WIDTH+2 cycles, independent of the operand values.
- `busy`=0 during the `done` cycle. A `start` in that cycle is accepted, giving back-to-back throughput of one result per WIDTH+2 cycles.
- **kill:** sampled at any edge while `busy`=1, it takes effect at that edge. State→IDLE, `busy`=0, results cleared, no `done`.
  - `kill` is ignored when `busy`=0 and has no effect on the results or on a coincident `start`.
  - `kill`+`start` in IDLE: `start` wins.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Structure
- **Package `muldiv_pkg`:**
  - Op encoding: MUL, MULU, DIV, DIVU.
  - State enum: IDLE, CALC, FIX.
  - Counter-width function: $clog2(WIDTH+1).
- **Sub-module `muldiv_addsub`:** (WIDTH+1)-bit add/subtract with a mode input and borrow out. It is shared by the shift-add accumulate, the trial subtract and the FIX negations. It is built from the existing 1-bit adder/subtractor cells.
- **Top `seq_muldiv`:** FSM, counter, operand/accumulator registers, special-case mux.

## Test plan
- **Signed MUL, WIDTH=32:** MUL a=7, b=0xFFFFFFFD → `result_lo`=0xFFFFFFEB, `result_hi`=0xFFFFFFFF. `done` occurs exactly 34 cycles after the `start` edge, and `busy` is high for 33 cycles.
- **Unsigned MUL:** MULU a=0xFFFFFFFF, b=0xFFFFFFFF → lo=0x00000001, hi=0xFFFFFFFE.
- **Division signs:**
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
- **Division special cases:**
  - DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Control:**
  - A `start` pulse at cycle 5 of an op is ignored, and the original result is unchanged.
  - `kill` at cycle 10 → `busy`=0 at cycle 11, results=0, no `done`.
  - `reset_n`=0 mid-op → all outputs 0 at the next cycle.
- **Back-to-back, WIDTH=8:** MUL a=0x80, b=0xFF → lo=0x80, hi=0x00 after 10 cycles. A `start` in the `done` cycle with DIVU a=200, b=7 → lo=28, hi=4 exactly 10 cycles later.
